// File: rtl/adsr_pkg.sv
// adsr_pkg: shared widths, ADSR encodings, context word layout and sequencer states
package adsr_pkg;
    localparam int STATE_W = 3;
    localparam int VOL_W   = 18;
    localparam logic [STATE_W-1:0] ADSR_IDLE = '0;
    typedef struct packed {
        logic [STATE_W-1:0] state;
        logic [VOL_W-1:0]   volume;
        logic               note_pressed;
        logic               note_released;
    } ctx_t;
    localparam int CTX_W = $bits(ctx_t);
    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_RD, S_EX} seq_state_t;
endpackage

// File: rtl/adsr_ctx_ram.sv
// adsr_ctx_ram: simple dual-port RAM, one write port and one registered read port
module adsr_ctx_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 23,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/adsr_voice_sequencer.sv
// adsr_voice_sequencer: sweeps every voice's envelope context through adsr_mngt2 once per sample tick
module adsr_voice_sequencer
    import adsr_pkg::*;
#(
    parameter int NUM_VOICES = 16,
    parameter int VOICE_W    = $clog2(NUM_VOICES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sample_tick,
    input  logic               note_on_valid,
    input  logic [VOICE_W-1:0] note_on_voice,
    input  logic               note_off_valid,
    input  logic [VOICE_W-1:0] note_off_voice,
    output logic [STATE_W-1:0] adsr_state,
    output logic [VOL_W-1:0]   adsr_volume,
    output logic               adsr_note_pressed,
    output logic               adsr_note_released,
    input  logic [STATE_W-1:0] adsr_o_state,
    input  logic [VOL_W-1:0]   adsr_o_volume,
    input  logic               adsr_o_note_pressed,
    input  logic               adsr_o_note_released,
    output logic               env_valid,
    output logic [VOICE_W-1:0] env_voice,
    output logic [VOL_W-1:0]   env_volume,
    output logic               sweep_done,
    output logic               busy,
    output logic               overrun
);
    seq_state_t state, nxt;
    logic [VOICE_W-1:0] cnt;
    logic [NUM_VOICES-1:0] pend_prs, pend_rel, clr_mask, on_mask, off_mask;
    ctx_t rd_ctx, wr_ctx;
    logic last, in_ex, wr_en;

    assign last     = cnt == VOICE_W'(NUM_VOICES - 1);
    assign in_ex    = state == S_EX;
    assign wr_en    = in_ex || state == S_CLEAR;
    assign on_mask  = note_on_valid ? NUM_VOICES'(1) << note_on_voice : '0;
    assign off_mask = note_off_valid ? NUM_VOICES'(1) << note_off_voice : '0;
    assign clr_mask = in_ex ? NUM_VOICES'(1) << cnt : '0;
    assign wr_ctx   = in_ex ? {adsr_o_state, adsr_o_volume, adsr_o_note_pressed, adsr_o_note_released}
                            : {ADSR_IDLE, {(VOL_W + 2){1'b0}}};

    assign adsr_state         = in_ex ? rd_ctx.state : '0;
    assign adsr_volume        = in_ex ? rd_ctx.volume : '0;
    assign adsr_note_pressed  = in_ex && (rd_ctx.note_pressed || pend_prs[cnt]);
    assign adsr_note_released = in_ex && (rd_ctx.note_released || pend_rel[cnt]);

    adsr_ctx_ram #(.DEPTH(NUM_VOICES), .WIDTH(CTX_W)) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (cnt),
        .wr_data (wr_ctx),
        .rd_addr (cnt),
        .rd_data (rd_ctx)
    );

    always_comb begin
        nxt = state;
        case (state)
            S_CLEAR: nxt = last ? S_IDLE : S_CLEAR;
            S_IDLE:  nxt = sample_tick ? S_RD : S_IDLE;
            S_RD:    nxt = S_EX;
            S_EX:    nxt = last ? S_IDLE : S_RD;
            default: nxt = S_CLEAR;
        endcase
    end

    // busy tracks the state register one edge late on entry but drops on the edge that returns to IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_CLEAR;
            cnt        <= '0;
            pend_prs   <= '0;
            pend_rel   <= '0;
            env_valid  <= 1'b0;
            env_voice  <= '0;
            env_volume <= '0;
            sweep_done <= 1'b0;
            busy       <= 1'b1;
            overrun    <= 1'b0;
        end else begin
            state      <= nxt;
            cnt        <= (wr_en && !last) ? cnt + 1'b1 : (state == S_RD) ? cnt : '0;
            pend_prs   <= (pend_prs & ~clr_mask) | on_mask;
            pend_rel   <= (pend_rel & ~clr_mask) | off_mask;
            env_valid  <= in_ex;
            env_voice  <= in_ex ? cnt : env_voice;
            env_volume <= in_ex ? adsr_o_volume : env_volume;
            sweep_done <= in_ex && last;
            busy       <= state != S_IDLE && nxt != S_IDLE;
            overrun    <= sample_tick && state != S_IDLE;
        end
    end
endmodule
